// File: rtl/cmd_frame_proc_if.sv
// Byte-wide 4-phase command and response links between the GSE host and the
// command-frame processor.
interface cmd_frame_proc_if;
  logic [7:0] cmd_data;
  logic       cmd_req;
  logic       cmd_ack;
  logic [7:0] rsp_data;
  logic       rsp_req;
  logic       rsp_ack;

  modport master (
    output cmd_data, cmd_req, rsp_ack,
    input  cmd_ack, rsp_data, rsp_req
  );

  modport slave (
    input  cmd_data, cmd_req, rsp_ack,
    output cmd_ack, rsp_data, rsp_req
  );
endinterface

// File: rtl/cmd_frame_proc.sv
// Assembles fixed-length command frames, runs one register read or write per
// frame and streams back a fixed-length response frame.
module cmd_frame_proc #(
  parameter int          P_FRAME_BYTES    = 17,
  parameter logic [7:0]  P_OP_GET         = 8'h01,
  parameter logic [7:0]  P_OP_SET         = 8'h02,
  parameter logic [7:0]  P_OP_ERR         = 8'hEE,
  parameter int          P_TIMEOUT_CYCLES = 50000
) (
  input  logic         clk,
  input  logic         rst,
  cmd_frame_proc_if.slave bus,
  output logic [7:0]   reg_addr_o,
  output logic         reg_wr_en_o,
  output logic [31:0]  reg_wr_data_o,
  output logic         reg_rd_en_o,
  input  logic [31:0]  reg_rd_data_i,
  output logic [7:0]   frame_err_cnt_o,
  output logic         busy_o
);

  localparam int CNT_W = $clog2(P_FRAME_BYTES);
  localparam int TO_W  = $clog2(P_TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(P_FRAME_BYTES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(P_TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    RX_IDLE, RX_ACK, EXEC, RD_WAIT, TX_REQ, TX_ACK
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] byte_cnt_q;
  logic [CNT_W-1:0] tx_cnt_q;
  logic [TO_W-1:0]  idle_cnt_q;
  logic [7:0]       frame_q [P_FRAME_BYTES];
  logic             cmd_ack_q;
  logic [7:0]       rsp_data_q;
  logic             rsp_req_q;
  logic [7:0]       reg_addr_q;
  logic             reg_wr_en_q;
  logic [31:0]      reg_wr_data_q;
  logic             reg_rd_en_q;
  logic [31:0]      rsp_word_q;
  logic [7:0]       op_rsp_q;
  logic [7:0]       err_cnt_q;
  logic             busy_q;

  logic [31:0]      frame_word_d;
  logic [CNT_W-1:0] tx_nxt_d;
  logic [7:0]       rsp_next_d;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Response layout: opcode, address, zero padding, 32-bit word big-endian.
  function automatic logic [7:0] rsp_byte(input logic [CNT_W-1:0] idx,
                                          input logic [7:0]       op,
                                          input logic [7:0]       addr,
                                          input logic [31:0]      word);
    int         pos;
    logic [7:0] b;
    pos = P_FRAME_BYTES - 1 - int'(idx);
    b   = 8'h00;
    if (idx == '0)               b = op;
    else if (idx == CNT_W'(1))   b = addr;
    else if (pos < 4)            b = 8'(word >> (8 * pos));
    return b;
  endfunction

  assign frame_word_d = {frame_q[P_FRAME_BYTES-4], frame_q[P_FRAME_BYTES-3],
                         frame_q[P_FRAME_BYTES-2], frame_q[P_FRAME_BYTES-1]};
  assign tx_nxt_d     = tx_cnt_q + 1'b1;
  assign rsp_next_d   = rsp_byte(tx_nxt_d, op_rsp_q, reg_addr_q, rsp_word_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RX_IDLE;
      byte_cnt_q    <= '0;
      tx_cnt_q      <= '0;
      idle_cnt_q    <= '0;
      cmd_ack_q     <= 1'b0;
      rsp_data_q    <= 8'h00;
      rsp_req_q     <= 1'b0;
      reg_addr_q    <= 8'h00;
      reg_wr_en_q   <= 1'b0;
      reg_wr_data_q <= 32'h0;
      reg_rd_en_q   <= 1'b0;
      rsp_word_q    <= 32'h0;
      op_rsp_q      <= 8'h00;
      err_cnt_q     <= 8'h00;
      busy_q        <= 1'b0;
      for (int i = 0; i < P_FRAME_BYTES; i++) frame_q[i] <= 8'h00;
    end else begin
      reg_wr_en_q <= 1'b0;
      reg_rd_en_q <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          if (bus.cmd_req && !cmd_ack_q) begin
            frame_q[byte_cnt_q] <= bus.cmd_data;
            cmd_ack_q           <= 1'b1;
            idle_cnt_q          <= '0;
            state_q             <= RX_ACK;
          end else if (byte_cnt_q != '0) begin
            // A stalled partial frame is dropped silently; only the error count records it.
            if (idle_cnt_q == TO_LAST) begin
              idle_cnt_q <= '0;
              byte_cnt_q <= '0;
              err_cnt_q  <= sat_inc(err_cnt_q);
            end else begin
              idle_cnt_q <= idle_cnt_q + 1'b1;
            end
          end
        end
        RX_ACK: begin
          if (!bus.cmd_req) begin
            cmd_ack_q <= 1'b0;
            if (byte_cnt_q == LAST_IDX) begin
              byte_cnt_q <= '0;
              busy_q     <= 1'b1;
              state_q    <= EXEC;
            end else begin
              byte_cnt_q <= byte_cnt_q + 1'b1;
              state_q    <= RX_IDLE;
            end
          end
        end
        EXEC: begin
          reg_addr_q <= frame_q[1];
          tx_cnt_q   <= '0;
          if (frame_q[0] == P_OP_GET) begin
            reg_rd_en_q <= 1'b1;
            op_rsp_q    <= P_OP_GET;
            state_q     <= RD_WAIT;
          end else if (frame_q[0] == P_OP_SET) begin
            reg_wr_en_q   <= 1'b1;
            reg_wr_data_q <= frame_word_d;
            rsp_word_q    <= frame_word_d;
            op_rsp_q      <= P_OP_SET;
            rsp_data_q    <= P_OP_SET;
            state_q       <= TX_REQ;
          end else begin
            err_cnt_q  <= sat_inc(err_cnt_q);
            rsp_word_q <= 32'h0;
            op_rsp_q   <= P_OP_ERR;
            rsp_data_q <= P_OP_ERR;
            state_q    <= TX_REQ;
          end
        end
        RD_WAIT: begin
          rsp_word_q <= reg_rd_data_i;
          rsp_data_q <= op_rsp_q;
          state_q    <= TX_REQ;
        end
        // rsp_data is loaded one cycle ahead of rsp_req so it is settled for the whole request.
        TX_REQ: begin
          if (!rsp_req_q) begin
            rsp_req_q <= 1'b1;
          end else if (bus.rsp_ack) begin
            rsp_req_q <= 1'b0;
            state_q   <= TX_ACK;
          end
        end
        TX_ACK: begin
          if (!bus.rsp_ack) begin
            if (tx_cnt_q == LAST_IDX) begin
              busy_q  <= 1'b0;
              state_q <= RX_IDLE;
            end else begin
              tx_cnt_q   <= tx_nxt_d;
              rsp_data_q <= rsp_next_d;
              state_q    <= TX_REQ;
            end
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign bus.cmd_ack     = cmd_ack_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_req     = rsp_req_q;
  assign reg_addr_o      = reg_addr_q;
  assign reg_wr_en_o     = reg_wr_en_q;
  assign reg_wr_data_o   = reg_wr_data_q;
  assign reg_rd_en_o     = reg_rd_en_q;
  assign frame_err_cnt_o = err_cnt_q;
  assign busy_o          = busy_q;

endmodule

// File: tb/tb_cmd_frame_proc.sv
// Randomized bench for cmd_frame_proc: frames are scored against a frame-level
// model of the expected response bytes, register strobes and error count.
module tb_cmd_frame_proc;
  localparam int N      = 17;
  localparam int TO     = 64;
  localparam int BUDGET = 6000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cmd_frame_proc_if bus();
  logic [7:0]  reg_addr, err_cnt;
  logic        wr_en, rd_en, busy;
  logic [31:0] wr_data, rd_data;

  cmd_frame_proc #(.P_FRAME_BYTES(N), .P_TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .reg_addr_o(reg_addr), .reg_wr_en_o(wr_en), .reg_wr_data_o(wr_data),
    .reg_rd_en_o(rd_en), .reg_rd_data_i(rd_data),
    .frame_err_cnt_o(err_cnt), .busy_o(busy)
  );

  function automatic logic [31:0] rd_model(input logic [7:0] a);
    if (a == 8'h00) return 32'h0001_0203;
    return {a, ~a, a ^ 8'h5A, a + 8'd1};
  endfunction
  assign rd_data = rd_model(reg_addr);

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", tag, act, exp);
    end
  endtask

  logic [7:0]  rx_q[$];
  logic [7:0]  exp_q[$];
  logic [63:0] stb_q[$];
  logic [63:0] exp_stb_q[$];
  logic [7:0]  frame_b [N];
  int ack_delay = 0;
  int exp_err = 0;
  int cyc = 0;
  int ack_fall_cyc = 0, rd_cyc = 0, first_req_cyc = -1;
  int stab_err = 0, ack_busy = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: strobes, handshake timing, rsp_data stability, backpressure.
  initial begin
    logic pv_ack, pv_req;
    logic [7:0] pv_data;
    pv_ack = 0; pv_req = 0; pv_data = 0;
    forever begin
      @(negedge clk);
      if (rd_en) begin
        stb_q.push_back({23'd0, 1'b0, reg_addr, 32'h0});
        rd_cyc = cyc;
      end
      if (wr_en) stb_q.push_back({23'd0, 1'b1, reg_addr, wr_data});
      if (pv_ack && !bus.cmd_ack) begin
        ack_fall_cyc  = cyc;
        first_req_cyc = -1;
      end
      if (bus.rsp_req && !pv_req && first_req_cyc < 0) first_req_cyc = cyc;
      if (bus.rsp_req && pv_req && bus.rsp_data !== pv_data) stab_err++;
      if (busy && bus.cmd_ack) ack_busy++;
      pv_ack = bus.cmd_ack; pv_req = bus.rsp_req; pv_data = bus.rsp_data;
    end
  end

  // Downstream receiver with configurable acknowledge delay.
  initial begin
    bus.rsp_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.rsp_req && !bus.rsp_ack) begin
        rx_q.push_back(bus.rsp_data);
        repeat (ack_delay) @(negedge clk);
        bus.rsp_ack = 1'b1;
        while (bus.rsp_req) @(negedge clk);
        bus.rsp_ack = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    bus.cmd_data = b;
    bus.cmd_req  = 1'b1;
    n = 0;
    while (bus.cmd_ack !== 1'b1 && n < BUDGET) begin @(negedge clk); n++; end
    if (n >= BUDGET) chk("cmd_ack_rise", 64'(bus.cmd_ack), 64'd1);
    bus.cmd_req = 1'b0;
    n = 0;
    while (bus.cmd_ack !== 1'b0 && n < BUDGET) begin @(negedge clk); n++; end
    if (n >= BUDGET) chk("cmd_ack_fall", 64'(bus.cmd_ack), 64'd0);
  endtask

  // Expected outcome of one complete frame, straight from the frame rules.
  task automatic model_frame();
    logic [7:0]  op, a;
    logic [31:0] d, wd;
    op = frame_b[0];
    a  = frame_b[1];
    wd = {frame_b[N-4], frame_b[N-3], frame_b[N-2], frame_b[N-1]};
    if (op == 8'h01) begin
      d = rd_model(a);
      exp_stb_q.push_back({23'd0, 1'b0, a, 32'h0});
    end else if (op == 8'h02) begin
      d = wd;
      exp_stb_q.push_back({23'd0, 1'b1, a, wd});
    end else begin
      d  = 32'h0;
      op = 8'hEE;
      exp_err = (exp_err >= 255) ? 255 : exp_err + 1;
    end
    exp_q.push_back(op);
    exp_q.push_back(a);
    for (int i = 2; i < N - 4; i++) exp_q.push_back(8'h00);
    for (int k = 3; k >= 0; k--) exp_q.push_back(d[8*k +: 8]);
  endtask

  task automatic send_frame(input int maxgap);
    for (int i = 0; i < N; i++) begin
      send_byte(frame_b[i]);
      if (maxgap > 0) repeat ($urandom_range(0, maxgap)) @(negedge clk);
    end
    model_frame();
  endtask

  task automatic fill(input logic [7:0] op, input logic [7:0] a);
    for (int i = 0; i < N; i++) frame_b[i] = 8'h00;
    frame_b[0] = op;
    frame_b[1] = a;
  endtask

  task automatic drain(input string tag);
    int n;
    int i;
    n = 0;
    while ((rx_q.size() < exp_q.size() || busy) && n < BUDGET) begin @(negedge clk); n++; end
    if (n >= BUDGET) begin
      chk({tag, "_rsp_wait"}, 64'(rx_q.size()), 64'(exp_q.size()));
      chk({tag, "_busy_end"}, 64'(busy), 64'd0);
    end
    repeat (2) @(negedge clk);
    chk({tag, "_rsp_len"}, 64'(rx_q.size()), 64'(exp_q.size()));
    i = 0;
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      chk($sformatf("%s_rsp_b%0d", tag, i), 64'(rx_q.pop_front()), 64'(exp_q.pop_front()));
      i++;
    end
    chk({tag, "_stb_len"}, 64'(stb_q.size()), 64'(exp_stb_q.size()));
    while (stb_q.size() > 0 && exp_stb_q.size() > 0)
      chk({tag, "_strobe"}, stb_q.pop_front(), exp_stb_q.pop_front());
    rx_q.delete(); exp_q.delete(); stb_q.delete(); exp_stb_q.delete();
    chk({tag, "_err_cnt"}, 64'(err_cnt), 64'(exp_err));
    chk({tag, "_rsp_stable"}, 64'(stab_err), 64'd0);
    chk({tag, "_ack_busy"}, 64'(ack_busy), 64'd0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_cmd_ack"}, 64'(bus.cmd_ack), 64'd0);
    chk({tag, "_rsp"}, 64'({bus.rsp_req, bus.rsp_data}), 64'd0);
    chk({tag, "_reg_addr"}, 64'(reg_addr), 64'd0);
    chk({tag, "_strobes"}, 64'({wr_en, rd_en}), 64'd0);
    chk({tag, "_wr_data"}, 64'(wr_data), 64'd0);
    chk({tag, "_err_cnt"}, 64'(err_cnt), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #900us;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst = 1'b1;
    bus.cmd_req  = 1'b0;
    bus.cmd_data = 8'h00;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // GET VNUM with latency
    fill(8'h01, 8'h00);
    send_frame(0);
    drain("get_vnum");
    chk("get_rd_lat", 64'(rd_cyc - ack_fall_cyc), 64'd1);
    chk("get_rsp_lat", 64'(first_req_cyc - ack_fall_cyc), 64'd3);

    // SET with echo
    fill(8'h02, 8'h10);
    frame_b[N-4] = 8'hDE; frame_b[N-3] = 8'hAD; frame_b[N-2] = 8'hBE; frame_b[N-1] = 8'hEF;
    send_frame(0);
    drain("set");
    chk("set_rsp_lat", 64'(first_req_cyc - ack_fall_cyc), 64'd2);

    // Unknown opcode
    fill(8'h7F, 8'h55);
    send_frame(0);
    drain("bad_op");
    chk("bad_op_err1", 64'(err_cnt), 64'd1);

    // Partial frame timeout, then a normal GET
    for (int i = 0; i < 5; i++) send_byte(8'($urandom));
    repeat (TO + 10) @(negedge clk);
    exp_err = exp_err + 1;
    chk("timeout_no_rsp", 64'(rx_q.size()), 64'd0);
    chk("timeout_err", 64'(err_cnt), 64'(exp_err));
    fill(8'h01, 8'h42);
    send_frame(0);
    drain("after_to");

    // Slow acknowledge with a command byte held pending during TX
    ack_delay = 100;
    fill(8'h01, 8'h33);
    send_frame(0);
    fill(8'h02, 8'h44);
    for (int i = N - 4; i < N; i++) frame_b[i] = 8'($urandom);
    send_frame(0);
    drain("backpressure");
    ack_delay = 0;

    // Reset in the middle of a frame
    fill(8'h02, 8'h21);
    frame_b[N-4] = 8'h11; frame_b[N-3] = 8'h22; frame_b[N-2] = 8'h33; frame_b[N-1] = 8'h44;
    for (int i = 0; i < 9; i++) send_byte(frame_b[i]);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_outputs_zero("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    exp_err = 0;
    repeat (2) @(negedge clk);
    send_frame(0);
    drain("post_reset");

    // Randomized frames
    for (int f = 0; f < 20; f++) begin
      int pick;
      pick = int'($urandom_range(0, 3));
      for (int i = 0; i < N; i++) frame_b[i] = 8'($urandom);
      if (pick <= 1) frame_b[0] = 8'h01;
      else if (pick == 2) frame_b[0] = 8'h02;
      ack_delay = int'($urandom_range(0, 3));
      send_frame(10);
      drain($sformatf("rnd%0d", f));
    end
    ack_delay = 0;

    // Error counter saturation via repeated timeouts
    for (int i = 0; i < 256; i++) begin
      send_byte(8'($urandom));
      repeat (TO + 5) @(negedge clk);
      exp_err = (exp_err >= 255) ? 255 : exp_err + 1;
    end
    chk("sat_err_cnt", 64'(err_cnt), 64'(exp_err));
    chk("sat_no_rsp", 64'(rx_q.size()), 64'd0);
    fill(8'h99, 8'h01);
    send_frame(0);
    drain("sat_bad_op");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
